ps2_rx_decoder: RTL and testbench
=================================

// Module: ps2_rx_decoder
// PURPOSE
//  Receives raw PS/2 keyboard clock/data lines, deframes 11-bit device-to-host frames and decodes
//  scancode set 2 prefixes (E0 extended, F0 break) into the 11-bit ps2_key event word
//  {toggle, pressed, extended, code[7:0]} consumed by the ps2_kbd Wishbone FIFO slave.
//  Receive-only: never drives or inhibits ps2 clock/data. Sits between the keyboard pins and ps2_kbd.
// PARAMETERS
//  SYNC_STAGES     2      synchronizer flops on ps2_clk_i and ps2_dat_i (>=2)
//  FILTER_LEN      8      clk_i cycles the synced PS/2 clock must be stable before the filtered value changes
//  TIMEOUT_CYCLES  10000  clk_i cycles without a sample edge mid-frame before abort (200us @ 50MHz)
// PORTS
//  clk_i      in   1   system clock
//  rst_i      in   1   asynchronous active-high reset
//  ps2_clk_i  in   1   raw PS/2 clock, asynchronous, idle high
//  ps2_dat_i  in   1   raw PS/2 data, asynchronous, idle high
//  ps2_key    out  11  [10] toggles per key event, [9] 1=make 0=break, [8] E0 prefix seen, [7:0] scancode
//  err_o      out  1   one-cycle pulse on framing, parity or timeout error
//  busy_o     out  1   high while a frame is in progress (state != RX_IDLE)
// BEHAVIOUR
//  Reset (async assert, sync deassert use of clk_i): ps2_key=0, err_o=0, busy_o=0, sync/filter flops=1,
//   FSM=RX_IDLE, bit counter/timeout=0, ext/brk/skip cleared. Reset mid-frame discards the frame.
//  Filter: clk_f takes synced clock value only after it is stable FILTER_LEN consecutive cycles.
//   sample = clk_f 1->0 transition; data bit = synced ps2_dat on that same cycle.
//  Frame FSM (one bit per sample):
//   RX_IDLE:   sample with data=0 (start) -> RX_DATA, cnt=0; sample with data=1 ignored.
//   RX_DATA:   shift in LSB first; after 8th bit -> RX_PARITY.
//   RX_PARITY: store bit -> RX_STOP.
//   RX_STOP:   data=1 and (^byte ^ parity)==1 (odd) -> byte_done; else err. Always -> RX_IDLE.
//  Timeout: counter cleared on every sample and in RX_IDLE; reaching TIMEOUT_CYCLES-1 outside
//   RX_IDLE -> RX_IDLE, err pulse, partial byte discarded.
//  Any err (parity, stop, timeout) also clears ext, brk and skip count.
//  Byte decode on byte_done (priority order):
//   skip>0: decrement, discard (pause sequence tail).
//   E1: skip=7 (drops E1 14 77 E1 F0 14 F0 77 whole), no event.
//   E0: ext=1. F0: brk=1. No event for either.
//   AA, FA, EE, FE, 00, FF: device responses, discarded, ext/brk cleared.
//   otherwise: ps2_key <= {~ps2_key[10], ~brk, ext, byte}; ext=0, brk=0.
//  Latency: ps2_key and err_o update on the clk_i edge after the stop-bit sample cycle.
//  All 11 ps2_key bits update on the same edge and hold until the next event (ps2_kbd
//   detects events by resynchronizing bit 10 only); at most one event per frame.
//  err_o is never asserted on the same cycle as a ps2_key update.
// TESTING (sim: TIMEOUT_CYCLES=200, PS/2 bit period 40 clk_i, FILTER_LEN=4)
//  1 frame 0x1C parity 0 -> ps2_key = {1,1,0,8'h1C} one cycle after stop; err_o stays 0.
//  2 F0 1C -> no change after F0; after 1C ps2_key = {0,0,0,8'h1C}.
//  3 E0 75 then E0 F0 75 -> {1,1,1,8'h75} then {0,0,1,8'h75}; prefixes alone never toggle bit 10.
//  4 E0 then 0x1C with parity 1 -> single err_o pulse, ps2_key unchanged; next 0x1C gives ext=0.
//  5 start + 4 bits then idle 250 cycles -> err_o pulse, busy_o falls; following 0x29 decodes {..,1,0,29}.
//  6 2-cycle low glitch on ps2_clk_i idle -> no sample; frames AA, FA, full E1 pause seq -> no toggle.

Source files
------------

// File: rtl/ps2_rx_decoder.sv
// ps2_rx_decoder
//   Receive-only PS/2 keyboard front end. It synchronizes and deglitches the
//   raw PS/2 clock, deframes 11-bit device-to-host frames (start, 8 data bits
//   LSB first, odd parity, stop) and decodes scancode set 2 prefixes into an
//   event word for the ps2_kbd FIFO slave. It never drives the PS/2 lines.
// Ports
//   clk_i     system clock
//   rst_i     asynchronous active-high reset
//   ps2_clk_i raw PS/2 clock (asynchronous, idle high)
//   ps2_dat_i raw PS/2 data  (asynchronous, idle high)
//   ps2_key   {toggle, make, extended, code[7:0]}; bit 10 flips once per event
//   err_o     one-cycle pulse on framing, parity or timeout error
//   busy_o    high while a frame is in progress
module ps2_rx_decoder #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ps2_clk_i,
  input  logic        ps2_dat_i,
  output logic [10:0] ps2_key,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_f_q, clk_f_d;
  logic [FLT_W-1:0]       flt_cnt_q, flt_cnt_d;
  rx_state_e              state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   ext_q, ext_d;
  logic                   brk_q, brk_d;
  logic [2:0]             skip_q, skip_d;
  logic [10:0]            key_q, key_d;
  logic                   err_q, err_d;

  logic clk_s;
  logic dat_s;
  logic sample;
  logic byte_done;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  // Synchronizers and PS/2 clock deglitch filter. The filtered clock only
  // follows the synced clock after it has differed for FILTER_LEN cycles;
  // the sample strobe fires on the cycle the filtered clock commits 1->0.
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
    clk_f_d    = clk_f_q;
    flt_cnt_d  = '0;
    sample     = 1'b0;
    if (clk_s != clk_f_q) begin
      if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
        clk_f_d = clk_s;
        sample  = clk_f_q & ~clk_s;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  // Frame FSM, inactivity timeout and scancode decode. Decode is folded into
  // the same cycle as the stop-bit sample so the event word and err_o both
  // register on the edge that closes the stop-bit cycle.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    skip_d    = skip_q;
    key_d     = key_q;
    err_d     = 1'b0;
    byte_done = 1'b0;

    if (sample) begin
      tmo_d = '0;
      unique case (state_q)
        RX_IDLE: begin
          if (!dat_s) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end
        end
        RX_DATA: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = dat_s;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          if (dat_s && ((^shift_q) ^ par_q)) byte_done = 1'b1;
          else                               err_d     = 1'b1;
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q == RX_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      tmo_d   = '0;
      state_d = RX_IDLE;
      err_d   = 1'b1;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    if (err_d) begin
      ext_d  = 1'b0;
      brk_d  = 1'b0;
      skip_d = '0;
    end else if (byte_done) begin
      if (skip_q != '0) begin
        skip_d = skip_q - 1'b1;
      end else begin
        unique case (shift_q)
          8'hE1: skip_d = 3'd7;
          8'hE0: ext_d  = 1'b1;
          8'hF0: brk_d  = 1'b1;
          8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
          default: begin
            key_d = {~key_q[10], ~brk_q, ext_q, shift_q};
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_f_q    <= 1'b1;
      flt_cnt_q  <= '0;
      state_q    <= RX_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      skip_q     <= '0;
      key_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_f_q    <= clk_f_d;
      flt_cnt_q  <= flt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      skip_q     <= skip_d;
      key_q      <= key_d;
      err_q      <= err_d;
    end
  end

  assign ps2_key = key_q;
  assign err_o   = err_q;
  assign busy_o  = (state_q != RX_IDLE);

endmodule

// File: tb/tb_ps2_rx_decoder.sv
module tb_ps2_rx_decoder;

  logic        clk;
  logic        rst;
  logic        ps2_clk;
  logic        ps2_dat;
  logic [10:0] ps2_key;
  logic        err_o;
  logic        busy_o;

  int n_vec;
  int n_bad;

  // Expected observations: {is_err, key word visible on that cycle}
  logic [11:0] exp_q[$];

  // Byte-level reference model state
  bit          m_ext;
  bit          m_brk;
  int          m_skip;
  logic [10:0] m_key;

  logic [10:0] prev_key;

  ps2_rx_decoder #(
    .SYNC_STAGES   (2),
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .ps2_clk_i(ps2_clk),
    .ps2_dat_i(ps2_dat),
    .ps2_key  (ps2_key),
    .err_o    (err_o),
    .busy_o   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: run did not complete (cycles=150000, required < 150000)");
    $fatal(1);
  end

  task automatic model_err();
    exp_q.push_back({1'b1, m_key});
    m_ext  = 0;
    m_brk  = 0;
    m_skip = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_skip > 0) begin
      m_skip = m_skip - 1;
    end else if (b == 8'hE1) begin
      m_skip = 7;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE ||
                 b == 8'h00 || b == 8'hFF) begin
      m_ext = 0;
      m_brk = 0;
    end else begin
      m_key = {~m_key[10], ~m_brk, m_ext, b};
      exp_q.push_back({1'b0, m_key});
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  // Drive nbits of a frame at a 40-cycle bit period, then update the model.
  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    if (nbits < 11) model_err();
    else if (bad_par || bad_stop) model_err();
    else model_byte(b);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_dat = bits[i];
      repeat (20) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk);
    ps2_dat = 1'b1;
    repeat ((nbits < 11) ? 260 : 30) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending byte=%02h: outstanding expected events=%0d, required 0",
               b, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every err pulse or key change must match the head of the queue.
  always @(negedge clk) begin
    logic [11:0] e;
    if (!rst) begin
      if (err_o || (ps2_key !== prev_key)) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected event: err=%0b key=%03h, required no event",
                   err_o, ps2_key);
        end else begin
          e = exp_q.pop_front();
          if ({err_o, ps2_key} !== e) begin
            n_bad++;
            $display("FAIL event: err=%0b key=%03h, required err=%0b key=%03h",
                     err_o, ps2_key, e[11], e[10:0]);
          end
        end
      end
      prev_key = ps2_key;
    end
  end

  initial begin
    logic [7:0] b;
    int         r;
    n_vec    = 0;
    n_bad    = 0;
    m_ext    = 0;
    m_brk    = 0;
    m_skip   = 0;
    m_key    = '0;
    prev_key = '0;
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_dat  = 1'b1;
    repeat (5) @(negedge clk);
    check("reset ps2_key", 32'(ps2_key), 32'h0);
    check("reset err_o", 32'(err_o), 32'h0);
    check("reset busy_o", 32'(busy_o), 32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    send_byte(8'h1C);
    check("make 1C", 32'(ps2_key), 32'h61C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("break 1C", 32'(ps2_key), 32'h01C);
    send_byte(8'hE0);
    send_byte(8'h75);
    check("ext make 75", 32'(ps2_key), 32'h775);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check("ext break 75", 32'(ps2_key), 32'h175);
    send_byte(8'hE0);
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    send_byte(8'h1C);
    check("ext cleared by err", 32'(ps2_key[8]), 32'h0);
    send_frame(8'h00, 1'b0, 1'b0, 5);
    check("busy after timeout", 32'(busy_o), 32'h0);
    send_byte(8'h29);
    check("make 29", 32'(ps2_key[9:0]), 32'h229);

    // Short low glitch on the clock with data low: must not start a frame.
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
    ps2_dat = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch busy", 32'(busy_o), 32'h0);

    send_byte(8'hAA);
    send_byte(8'hFA);
    b = ps2_key[7:0];
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    check("pause seq no event", 32'(ps2_key[7:0]), 32'(b));
    send_byte(8'h1C);
    check("after pause", 32'(ps2_key[9:0]), 32'h21C);

    for (int i = 0; i < 50; i++) begin
      r = int'($urandom_range(0, 15));
      case (r)
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = 8'hE1;
        5:       b = 8'hAA;
        default: b = 8'($urandom);
      endcase
      r = int'($urandom_range(0, 19));
      if (r == 0)      send_frame(b, 1'b1, 1'b0, 11);
      else if (r == 1) send_frame(b, 1'b0, 1'b1, 11);
      else if (r == 2) send_frame(b, 1'b0, 1'b0, int'($urandom_range(1, 10)));
      else             send_byte(b);
    end
    check("final key", 32'(ps2_key), 32'(m_key));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
